mcycle_issue: RTL and testbench
===============================

Name: mcycle_issue

Overview:
- Issue/retire sequencer placed directly upstream of the MCycle multi-cycle multiply/divide unit.
- Accepts one mul/div request from the datapath over a valid/ready handshake and latches the operands.
- Drives MCycle's Start/MCycleOp/Operand1/Operand2, tracks its Busy protocol, and captures Result1/Result2.
- Returns results with the destination tag over a second valid/ready handshake, and provides a Busy/stall indication to the pipeline.

Parameters:
- WIDTH, 32, operand/result width; must equal the MCycle width.
- TAG_W, 4, width of the destination-register tag carried with the request.
- LAT_W, 8, width of the latency counter; saturating.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  block can accept a request.
- ReqOp  input  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- ReqA  input  WIDTH  operand 1 (multiplicand/dividend).
- ReqB  input  WIDTH  operand 2 (multiplier/divisor).
- ReqTag  input  TAG_W  destination tag.
- MC_Start  output  1  to MCycle Start.
- MC_Op  output  2  to MCycle MCycleOp.
- MC_Operand1  output  WIDTH  to MCycle Operand1.
- MC_Operand2  output  WIDTH  to MCycle Operand2.
- MC_Result1  input  WIDTH  from MCycle: product low word / quotient.
- MC_Result2  input  WIDTH  from MCycle: product high word / remainder.
- MC_Busy  input  1  from MCycle Busy.
- RspValid  output  1  response present.
- RspReady  input  1  consumer accepts the response.
- RspLo  output  WIDTH  captured Result1.
- RspHi  output  WIDTH  captured Result2.
- RspTag  output  TAG_W  tag of the completed request.
- RspCycles  output  LAT_W  cycles from entering ISSUE until result capture.
- Busy  output  1  high whenever state is not IDLE (pipeline stall source).

Behaviour:
- Reset: the async reset forces state=IDLE and clears all registers.
  - RspValid=0, RspLo=0, RspHi=0, RspTag=0, RspCycles=0.
  - MC_Start=0, MC_Op=0, MC_Operand1=0, MC_Operand2=0, Busy=0.
  - ReqReady=1, because it decodes IDLE.
- Output decoding:
  - ReqReady = (state==IDLE); MC_Start = (state==ISSUE); Busy = (state!=IDLE).
  - MC_Op and MC_Operand1/2 come from request latches; they are held constant in every non-IDLE state.
- IDLE: on ReqValid&&ReqReady at a rising edge, latch ReqOp, ReqA, ReqB, ReqTag, clear the latency counter, then go to ISSUE.
- ISSUE:
  - MC_Start=1.
  - The latency counter increments each cycle.
  - When MC_Busy is sampled 1, go to WAIT. MCycle raises Busy the cycle after Start, so ISSUE normally lasts 1 cycle.
- WAIT:
  - MC_Start=0, so MCycle cannot restart back-to-back.
  - The counter increments each cycle.
  - When MC_Busy is sampled 0, capture MC_Result1→RspLo, MC_Result2→RspHi, latched tag→RspTag and counter→RspCycles, then go to DONE.
- DONE:
  - RspValid=1; RspLo, RspHi, RspTag and RspCycles are held stable.
  - On RspReady, go to IDLE and drop RspValid next cycle.
  - A new request cannot be accepted in the same cycle as retirement; the minimum gap is 1 IDLE cycle.
- Counter: saturates at 2^LAT_W−1 and does not wrap.
- ReqValid while not IDLE: ignored; the requester must hold the request.
- Back-pressure: RspReady=0 holds DONE indefinitely; no MCycle activity occurs meanwhile.
- Reset mid-operation: returns to IDLE immediately and any in-flight result is discarded. MCycle shares RESET.
- Arithmetic/sign handling is performed entirely by MCycle; this block never modifies result bits.

Optional Feature:
- Macro: MCYCLE_DIV0_BYPASS_EN.
- Defined:
  - If ReqOp[1]==1 (divide) and ReqB==0 at acceptance, skip ISSUE/WAIT and enter DONE on the next edge with RspLo=all ones, RspHi=ReqA, RspCycles=0.
  - MC_Start is never asserted for that request.
- Undefined: divide-by-zero is issued to MCycle like any other request and returns whatever MCycle produces.

Test Plan:
- WIDTH=4, signed mul A=1111, B=1111 → one MC_Start pulse; RspLo=0001, RspHi=0000; RspCycles equals MCycle latency+1.
- WIDTH=4, signed mul A=0101, B=1110 → RspLo=0110, RspHi=1111 (−10).
- Unsigned div A=1111, B=0100, then signed div A=0111, B=1101 → responses are Lo=0011 Hi=0011, then Lo=1110 Hi=0001, each carrying its own tag.
- Unsigned mul A=0011, B=0100 with RspReady held 0 for 5 cycles after RspValid → RspValid stays 1, outputs stable, ReqReady=0, MC_Start=0 throughout; RspLo=1100 then retires.
- RESET asserted for 1 cycle during WAIT → all outputs zero, ReqReady=1 immediately; the next request completes correctly.
- With MCYCLE_DIV0_BYPASS_EN: unsigned div A=1001, B=0000 → RspValid 1 cycle after acceptance, RspLo=1111, RspHi=1001, RspCycles=0, MC_Start never high.

Source files
------------

// File: rtl/mcycle_issue.sv
// Issue/retire sequencer in front of the MCycle multiply/divide unit.
// Optional macro MCYCLE_DIV0_BYPASS_EN: divide-by-zero retires directly without starting MCycle.
module mcycle_issue #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int LAT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [1:0]       ReqOp,
    input  logic [WIDTH-1:0] ReqA,
    input  logic [WIDTH-1:0] ReqB,
    input  logic [TAG_W-1:0] ReqTag,
    output logic             MC_Start,
    output logic [1:0]       MC_Op,
    output logic [WIDTH-1:0] MC_Operand1,
    output logic [WIDTH-1:0] MC_Operand2,
    input  logic [WIDTH-1:0] MC_Result1,
    input  logic [WIDTH-1:0] MC_Result2,
    input  logic             MC_Busy,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspLo,
    output logic [WIDTH-1:0] RspHi,
    output logic [TAG_W-1:0] RspTag,
    output logic [LAT_W-1:0] RspCycles,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAITING,
        DONE
    } state_t;

    state_t state, state_next;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TAG_W-1:0] tag_q;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] rsp_lo;
    logic [WIDTH-1:0] rsp_hi;
    logic [TAG_W-1:0] rsp_tag;
    logic [LAT_W-1:0] rsp_cycles;
    logic             accept;
    logic             div0;

    assign accept  = ReqValid && (state == IDLE);
    assign cnt_inc = (cnt == {LAT_W{1'b1}}) ? cnt : cnt + 1'b1;

`ifdef MCYCLE_DIV0_BYPASS_EN
    assign div0 = ReqOp[1] && (ReqB == '0);
`else
    assign div0 = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ReqReady   = 1'b0;
        MC_Start   = 1'b0;
        RspValid   = 1'b0;
        Busy       = 1'b1;
        case (state)
            IDLE: begin
                ReqReady = 1'b1;
                Busy     = 1'b0;
                if (accept) begin
                    state_next = div0 ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                MC_Start = 1'b1;
                if (MC_Busy) begin
                    state_next = WAITING;
                end
            end
            WAITING: begin
                if (!MC_Busy) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                RspValid = 1'b1;
                if (RspReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latches feed MCycle directly; they only change on acceptance, so the
    // operands stay put for the whole operation. The response registers hold until
    // the next capture, which keeps them stable under back-pressure in DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            cnt        <= '0;
            rsp_lo     <= '0;
            rsp_hi     <= '0;
            rsp_tag    <= '0;
            rsp_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= ReqOp;
                        a_q   <= ReqA;
                        b_q   <= ReqB;
                        tag_q <= ReqTag;
                        cnt   <= '0;
                        if (div0) begin
                            rsp_lo     <= '1;
                            rsp_hi     <= ReqA;
                            rsp_tag    <= ReqTag;
                            rsp_cycles <= '0;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt_inc;
                end
                WAITING: begin
                    cnt <= cnt_inc;
                    if (!MC_Busy) begin
                        rsp_lo     <= MC_Result1;
                        rsp_hi     <= MC_Result2;
                        rsp_tag    <= tag_q;
                        rsp_cycles <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign MC_Op       = op_q;
    assign MC_Operand1 = a_q;
    assign MC_Operand2 = b_q;
    assign RspLo       = rsp_lo;
    assign RspHi       = rsp_hi;
    assign RspTag      = rsp_tag;
    assign RspCycles   = rsp_cycles;

endmodule

// File: tb/tb_mcycle_issue.sv
// Directed bench for mcycle_issue at WIDTH=4, LAT_W=3 with a behavioural MCycle stand-in.
// Covers the MCYCLE_DIV0_BYPASS_EN path when that macro is defined.
module tb_mcycle_issue;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ReqValid = 1'b0;
    logic       ReqReady;
    logic [1:0] ReqOp = 2'b00;
    logic [3:0] ReqA = 4'h0;
    logic [3:0] ReqB = 4'h0;
    logic [3:0] ReqTag = 4'h0;
    logic       MC_Start;
    logic [1:0] MC_Op;
    logic [3:0] MC_Operand1;
    logic [3:0] MC_Operand2;
    logic [3:0] MC_Result1;
    logic [3:0] MC_Result2;
    logic       MC_Busy;
    logic       RspValid;
    logic       RspReady = 1'b0;
    logic [3:0] RspLo;
    logic [3:0] RspHi;
    logic [3:0] RspTag;
    logic [2:0] RspCycles;
    logic       Busy;

    int vectors = 0;
    int miscompares = 0;
    int start_count = 0;
    int mc_lat = 3;
    int mc_left;
    logic mc_run;

    mcycle_issue #(.WIDTH(4), .TAG_W(4), .LAT_W(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
        .ReqA(ReqA), .ReqB(ReqB), .ReqTag(ReqTag),
        .MC_Start(MC_Start), .MC_Op(MC_Op),
        .MC_Operand1(MC_Operand1), .MC_Operand2(MC_Operand2),
        .MC_Result1(MC_Result1), .MC_Result2(MC_Result2), .MC_Busy(MC_Busy),
        .RspValid(RspValid), .RspReady(RspReady),
        .RspLo(RspLo), .RspHi(RspHi), .RspTag(RspTag), .RspCycles(RspCycles),
        .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] mcCompute(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sp;
        logic signed [3:0] sa, sb, sq, sr;
        logic [7:0] up;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                sp = 8'(sa) * 8'(sb);
                return sp;
            end
            2'b01: begin
                up = {4'h0, a} * {4'h0, b};
                return up;
            end
            2'b10: begin
                if (b == 4'h0) return {a, 4'hf};
                sq = sa / sb;
                sr = sa % sb;
                return {sr, sq};
            end
            default: begin
                if (b == 4'h0) return {a, 4'hf};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Busy rises combinationally with Start and stays high for mc_lat more cycles.
    assign MC_Busy = MC_Start | mc_run;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mc_run     <= 1'b0;
            mc_left    <= 0;
            MC_Result1 <= 4'h0;
            MC_Result2 <= 4'h0;
        end else if (mc_run) begin
            if (mc_left <= 1) mc_run <= 1'b0;
            else mc_left <= mc_left - 1;
        end else if (MC_Start) begin
            mc_run  <= 1'b1;
            mc_left <= mc_lat;
            {MC_Result2, MC_Result1} <= mcCompute(MC_Op, MC_Operand1, MC_Operand2);
        end
    end

    always @(posedge CLK) begin
        if (MC_Start) start_count <= start_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] tag);
        @(negedge CLK);
        ReqOp    = op;
        ReqA     = a;
        ReqB     = b;
        ReqTag   = tag;
        ReqValid = 1'b1;
        @(negedge CLK);
        ReqValid = 1'b0;
    endtask

    task automatic runTxn(input string name, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] tag, input logic [3:0] exp_lo, input logic [3:0] exp_hi,
                          input logic [2:0] exp_cyc, input int exp_starts, input int hold);
        int starts0;
        starts0 = start_count;
        applyStimulus(op, a, b, tag);
        for (int i = 0; i < 40 && !RspValid; i++) @(negedge CLK);
        if (!RspValid) checkOutput({name, "_timeout"}, 32'(RspValid), 32'd1);
        checkOutput({name, "_lo"}, 32'(RspLo), 32'(exp_lo));
        checkOutput({name, "_hi"}, 32'(RspHi), 32'(exp_hi));
        checkOutput({name, "_tag"}, 32'(RspTag), 32'(tag));
        checkOutput({name, "_cycles"}, 32'(RspCycles), 32'(exp_cyc));
        if (hold > 0) begin
            ReqOp    = 2'b11;
            ReqA     = 4'hf;
            ReqB     = 4'h1;
            ReqValid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            checkOutput({name, "_hold_valid"}, 32'(RspValid), 32'd1);
            checkOutput({name, "_hold_lo"}, 32'(RspLo), 32'(exp_lo));
            checkOutput({name, "_hold_ready"}, 32'(ReqReady), 32'd0);
            checkOutput({name, "_hold_start"}, 32'(MC_Start), 32'd0);
            checkOutput({name, "_hold_opnd"}, 32'(MC_Operand1), 32'(a));
        end
        ReqValid = 1'b0;
        RspReady = 1'b1;
        @(negedge CLK);
        RspReady = 1'b0;
        checkOutput({name, "_retired"}, 32'(RspValid), 32'd0);
        checkOutput({name, "_idle_ready"}, 32'(ReqReady), 32'd1);
        checkOutput({name, "_starts"}, 32'(start_count - starts0), 32'(exp_starts));
    endtask

    initial begin
        #1;
        checkOutput("reset_ready", 32'(ReqReady), 32'd1);
        checkOutput("reset_busy", 32'(Busy), 32'd0);
        checkOutput("reset_rsp", {RspValid, RspLo, RspHi, RspTag, RspCycles}, 32'd0);
        checkOutput("reset_mc", {MC_Start, MC_Op, MC_Operand1, MC_Operand2}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // ISSUE 1 + Busy 3 more + capture cycle = 5.
        runTxn("smul_m1m1", 2'b00, 4'b1111, 4'b1111, 4'h3, 4'b0001, 4'b0000, 3'd5, 1, 0);
        runTxn("smul_5m2", 2'b00, 4'b0101, 4'b1110, 4'h4, 4'b0110, 4'b1111, 3'd5, 1, 0);
        runTxn("udiv_15_4", 2'b11, 4'b1111, 4'b0100, 4'h5, 4'b0011, 4'b0011, 3'd5, 1, 0);
        runTxn("sdiv_7m3", 2'b10, 4'b0111, 4'b1101, 4'h6, 4'b1110, 4'b0001, 3'd5, 1, 0);
        runTxn("umul_bp", 2'b01, 4'b0011, 4'b0100, 4'h7, 4'b1100, 4'b0000, 3'd5, 1, 5);

        // 1 + 8 + 1 = 10 cycles, saturates at 7 in a 3-bit counter.
        mc_lat = 8;
        runTxn("umul_sat", 2'b01, 4'b0010, 4'b0011, 4'h8, 4'b0110, 4'b0000, 3'd7, 1, 0);
        mc_lat = 3;

        applyStimulus(2'b01, 4'b0111, 4'b0111, 4'h9);
        @(negedge CLK);
        checkOutput("pre_reset_busy", 32'(Busy), 32'd1);
        RESET = 1'b1;
        #1;
        checkOutput("midrst_ready", 32'(ReqReady), 32'd1);
        checkOutput("midrst_busy", 32'(Busy), 32'd0);
        checkOutput("midrst_rsp", {RspValid, RspLo, RspHi, RspTag, RspCycles}, 32'd0);
        checkOutput("midrst_mc", {MC_Start, MC_Op, MC_Operand1, MC_Operand2}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        runTxn("after_rst", 2'b00, 4'b0011, 4'b1110, 4'ha, 4'b1010, 4'b1111, 3'd5, 1, 0);

`ifdef MCYCLE_DIV0_BYPASS_EN
        runTxn("div0_bypass", 2'b11, 4'b1001, 4'b0000, 4'hb, 4'b1111, 4'b1001, 3'd0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
